// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner state encoding, column drive patterns and key index helpers
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    localparam int KEY_W = 4;
    localparam logic [3:0][3:0] COL_PAT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    function automatic logic [1:0] low_row(input logic [3:0] r);
        return !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/row_sync.sv
// row_sync: two-flop synchronizer for active-low inputs, resets to all-ones
module row_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         re,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or negedge re)
        if (!re) {q, meta} <= '1;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with press/release debounce
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic             clk,
    input  logic             re,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT);
    state_t state, state_d;
    logic [3:0] row_s, cap, cap_d;
    logic [1:0] col_idx, col_d;
    logic [DIV_W-1:0] div, div_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [KEY_W-1:0] code_d;
    logic valid_d, held_d, idle, match, last, dlast;

    row_sync #(.W(4)) u_sync (.clk(clk), .re(re), .d(row), .q(row_s));

    assign col   = COL_PAT[col_idx];
    assign idle  = row_s == 4'b1111;
    assign match = row_s == cap;
    assign last  = div == DIV_W'(SCAN_DIV - 1);
    assign dlast = cnt == CNT_W'(DEBOUNCE_CNT - 1);

    always_ff @(posedge clk or negedge re)
        if (!re) begin
            state     <= SCAN;
            col_idx   <= '0;
            div       <= '0;
            cnt       <= '0;
            cap       <= 4'b1111;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_d;
            col_idx   <= col_d;
            div       <= div_d;
            cnt       <= cnt_d;
            cap       <= cap_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end

    // Counters only ever count up to their terminal value, then the state changes and clears them.
    always_comb begin
        state_d = state;
        col_d   = col_idx;
        div_d   = div;
        cnt_d   = cnt;
        cap_d   = cap;
        code_d  = key_code;
        valid_d = 1'b0;
        held_d  = key_held;
        unique case (state)
            SCAN:
                if (!last) div_d = div + 1'b1;
                else begin
                    div_d = '0;
                    if (idle) col_d = col_idx + 2'd1;
                    else begin
                        cap_d   = row_s;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
            DEBOUNCE:
                if (!match) begin
                    state_d = SCAN;
                    col_d   = col_idx + 2'd1;
                    cnt_d   = '0;
                    div_d   = '0;
                end else if (dlast) begin
                    state_d = HELD;
                    code_d  = KEY_W'({low_row(cap), col_idx});
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    cnt_d   = '0;
                end else cnt_d = cnt + 1'b1;
            HELD:
                if (idle) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            RELEASE:
                if (!idle) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (dlast) begin
                    state_d = SCAN;
                    held_d  = 1'b0;
                    col_d   = col_idx + 2'd1;
                    cnt_d   = '0;
                    div_d   = '0;
                end else cnt_d = cnt + 1'b1;
            default: state_d = SCAN;
        endcase
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: table-driven and scenario checks of keypad_scan with SCAN_DIV=8, DEBOUNCE_CNT=16
module tb_keypad_scan;
    logic clk = 1'b0;
    logic re = 1'b0;
    logic [3:0] row = 4'hf;
    logic [3:0] col, key_code;
    logic key_valid, key_held;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic       valid;
        logic       held;
        logic [3:0] code;
    } vec_t;
    vec_t vecs [33];
    vec_t sb [$];
    logic [3:0] col_seq [4];

    keypad_scan #(.SCAN_DIV(8), .DEBOUNCE_CNT(16)) dut (
        .clk(clk), .re(re), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic v, input logic h, input logic [3:0] k);
        vec_t e;
        e.row = row; e.col = c; e.valid = v; e.held = h; e.code = k;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string name);
        vec_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        chk({name, " col"}, col, e.col);
        chk({name, " valid"}, {3'b0, key_valid}, {3'b0, e.valid});
        chk({name, " held"}, {3'b0, key_held}, {3'b0, e.held});
        chk({name, " code"}, key_code, e.code);
    endtask

    task automatic run(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (key_valid) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic do_reset();
        re  = 1'b0;
        row = 4'hf;
        #1;
        push(4'hE, 1'b0, 1'b0, 4'h0);
        check_sb("reset");
        @(negedge clk);
        tick(2);
        re = 1'b1;
    endtask

    initial begin
        int p, f, k;
        col_seq = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int i = 0; i < 33; i++)
            vecs[i] = '{row: 4'hf, col: col_seq[(i / 8) % 4], valid: 1'b0, held: 1'b0, code: 4'h0};
        @(negedge clk);
        do_reset();

        // idle scan: 8 samples per column, wrapping back to column 0
        for (int i = 0; i < 33; i++) begin
            row = vecs[i].row;
            sb.push_back(vecs[i]);
            check_sb($sformatf("idle[%0d]", i));
            tick();
        end

        // single press on row 2 / column 1
        do_reset();
        tick(8);
        push(4'hD, 1'b0, 1'b0, 4'h0);
        check_sb("press pre");
        row = 4'b1011;
        run(40, p, f);
        chk("press pulses", 4'(p), 4'd1);
        chk("press latency", 4'(f - 16), 4'd8);
        push(4'hD, 1'b0, 1'b1, 4'd9);
        check_sb("press held");

        // release with re-bounce: held survives, clears after the stable debounce
        row = 4'b1111; tick();
        row = 4'b1011; tick();
        row = 4'b1111; tick();
        row = 4'b1011; tick();
        row = 4'b1111;
        push(4'hD, 1'b0, 1'b1, 4'd9);
        check_sb("bounce held");
        p = 0;
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            tick();
            if (key_valid) p++;
            if (!key_held) k = i;
        end
        chk("release delay", 4'(k - 10), 4'd9);
        chk("release pulses", 4'(p), 4'd0);
        push(4'hB, 1'b0, 1'b0, 4'd9);
        check_sb("released");

        // bouncing during debounce never accepts
        do_reset();
        tick(8);
        p = 0;
        for (int i = 8; i < 46; i++) begin
            row = (i < 18) ? 4'b1011 : (((i - 18) / 5) % 2 == 0) ? 4'b1111 : 4'b1011;
            if (i == 21) begin
                push(4'hB, 1'b0, 1'b0, 4'h0);
                check_sb("bounce abort");
            end
            tick();
            if (key_valid) p++;
        end
        chk("bounce pulses", 4'(p), 4'd0);
        row = 4'hf;

        // two rows low on column 3: lowest row wins
        do_reset();
        tick(24);
        push(4'h7, 1'b0, 1'b0, 4'h0);
        check_sb("multi pre");
        row = 4'b0110;
        run(30, p, f);
        chk("multi pulses", 4'(p), 4'd1);
        chk("multi latency", 4'(f - 16), 4'd8);
        push(4'h7, 1'b0, 1'b1, 4'd3);
        check_sb("multi held");

        // asynchronous reset while held, key still down afterwards
        #2 re = 1'b0;
        #1;
        push(4'hE, 1'b0, 1'b0, 4'h0);
        check_sb("async reset");
        @(negedge clk);
        tick(2);
        re = 1'b1;
        push(4'hE, 1'b0, 1'b0, 4'h0);
        check_sb("post reset");
        run(30, p, f);
        chk("fresh pulses", 4'(p), 4'd1);
        chk("fresh latency", 4'(f - 16), 4'd8);
        push(4'hE, 1'b0, 1'b1, 4'd0);
        check_sb("fresh held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The parameter SCAN_DIV SHALL default to 50000 and set the clk cycles each column is driven (>= 4).
REQ-002 The parameter DEBOUNCE_CNT SHALL default to 500000 and set the consecutive stable clk cycles required for press and release (>= 2).
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-004 Port re SHALL be an input, 1 bit wide, and is the reset: asynchronous, active-low.
REQ-005 Port row SHALL be an input, 4 bits wide, carrying the keypad row lines: asynchronous, active-low, pulled up externally.
REQ-006 Port col SHALL be an output, 4 bits wide, carrying the keypad column drive: active-low, exactly one bit low at all times.
REQ-007 Port key_code SHALL be an output, 4 bits wide, holding the last debounced key index, row_idx*4 + col_idx.
REQ-008 Port key_valid SHALL be an output, 1 bit wide, pulsing high for one cycle per accepted press.
REQ-009 Port key_held SHALL be an output, 1 bit wide, high from the accepted press until the accepted release.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer (row_s) before any use; row_s resets to 4'b1111.
REQ-011 col SHALL step through 4'b1110 -> 4'b1101 -> 4'b1011 -> 4'b0111 -> 4'b1110, one step per SCAN_DIV cycles, in state SCAN only.
REQ-012 col_idx SHALL be 0..3 for the low bit position of col; row_idx SHALL be 0..3 for the low bit of row_s.
REQ-013 The FSM SHALL have states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-014 SCAN: row_s SHALL be sampled only on the last cycle of a column dwell; if row_s != 4'b1111, the block SHALL capture col_idx and row_s, hold col, clear the debounce counter and enter DEBOUNCE; otherwise col advances.
REQ-015 Multiple low rows SHALL resolve to the lowest row_idx.
REQ-016 DEBOUNCE: the counter SHALL increment each cycle that row_s equals the captured pattern; any mismatch SHALL return to SCAN with col advancing to the next column.
REQ-017 When the counter reaches DEBOUNCE_CNT-1 with a match, the next cycle SHALL set key_code, pulse key_valid, set key_held and enter HELD.
REQ-018 HELD: col SHALL stay frozen; the first cycle with row_s == 4'b1111 SHALL clear the counter and enter RELEASE.
REQ-019 RELEASE: the counter SHALL increment while row_s == 4'b1111; any low row SHALL return to HELD with no new key_valid.
REQ-020 On DEBOUNCE_CNT consecutive released cycles, the block SHALL clear key_held, return to SCAN and advance col.
REQ-021 key_code SHALL hold its value until the next accepted press.
REQ-022 Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap; each SHALL saturate and clear on state change.
REQ-023 A second key pressed while HELD SHALL be ignored until release completes.

Reset
REQ-024 While re = 0: col = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, state = SCAN, counters = 0, row_s = 4'b1111.
REQ-025 An assertion of re in any state, mid-press included, SHALL take effect immediately; after deassertion, scanning SHALL restart at column 0 and no key_valid SHALL be emitted for a key already down until it is debounced afresh.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum, the four col patterns and the key_code width.
REQ-027 The synchronizer SHALL be a sub-module named row_sync (parameterised width, reset value all-ones).
REQ-028 The RTL target SHALL be 120-400 lines.

Verification (SCAN_DIV=8, DEBOUNCE_CNT=16)
REQ-029 Reset then idle, row=1111 -> col sequence 1110,1101,1011,0111, 8 cycles each; key_valid never high.
REQ-030 Hold row=1011 while col=1101 for 40 cycles -> exactly one key_valid pulse; key_code=9 (row 2, col 1); key_held=1; col frozen at 1101.
REQ-031 Bounce row between 1011 and 1111 every 5 cycles during DEBOUNCE -> no key_valid; return to SCAN; col advances to 1011.
REQ-032 After an accepted press, release with 3 cycles of re-bounce, then stable 1111 -> key_held stays 1 through the bounce and clears exactly 16 stable cycles later; no second key_valid.
REQ-033 Rows 0 and 3 both low on col 0111 -> key_code=3 (lowest row wins).
REQ-034 Drive re=0 during HELD, then release re with the key still down -> outputs at reset values; col=1110; key_valid fires only after a fresh 16-cycle debounce.
